// File: rtl/decodificador_n_seq_if.sv
// Bus bundle for decodificador_n_seq: control/select inputs and decoded outputs.
// f_par exists only when DECOD_PAR_EN is defined.
interface decodificador_n_seq_if #(
    parameter int N = 2
);
    logic              en;
    logic              modo;
    logic              load;
    logic [N-1:0]      sel;
    logic [(1<<N)-1:0] Y;
    logic [N-1:0]      idx;
    logic              wrap;
`ifdef DECOD_PAR_EN
    logic              f_par;

    modport master (output en, modo, load, sel, input Y, idx, wrap, f_par);
    modport slave  (input en, modo, load, sel, output Y, idx, wrap, f_par);
`else
    modport master (output en, modo, load, sel, input Y, idx, wrap);
    modport slave  (input en, modo, load, sel, output Y, idx, wrap);
`endif
endinterface

// File: rtl/decodificador_n_seq.sv
// Registered N->2^N one-hot decoder with enable blanking, direct load and prescaled auto-scan.
// Optional DECOD_PAR_EN adds f_par, the OR of the even-index outputs.
module decodificador_n_seq #(
    parameter int N        = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    decodificador_n_seq_if.slave  bus
);
    localparam int              W        = 1 << N;
    localparam int              PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [N-1:0]    IDX_LAST = '1;

    logic [N-1:0]  idx_q, idx_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [W-1:0]  y_q, y_d;
    logic          wrap_q, wrap_d;

    always_comb begin
        idx_d  = idx_q;
        pre_d  = pre_q;
        wrap_d = 1'b0;
        if (bus.en) begin
            if (bus.modo) begin
                if (pre_q == PRE_LAST) begin
                    pre_d  = '0;
                    idx_d  = idx_q + 1'b1;
                    wrap_d = (idx_q == IDX_LAST);
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end else begin
                // Direct mode keeps the prescaler cleared so a later scan starts a full period.
                pre_d = '0;
                if (bus.load) begin
                    idx_d = bus.sel;
                end
            end
        end
    end

    // Output register decodes the index being written this edge, so Y and idx move together.
    for (genvar gi = 0; gi < W; gi++) begin : g_decode
        assign y_d[gi] = bus.en & (idx_d == N'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            pre_q  <= '0;
            y_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            pre_q  <= pre_d;
            y_q    <= y_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.Y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

`ifdef DECOD_PAR_EN
    logic [W/2-1:0] even_bits;
    for (genvar gi = 0; gi < W/2; gi++) begin : g_even
        assign even_bits[gi] = y_q[2*gi];
    end
    assign bus.f_par = |even_bits;
`endif

endmodule

// File: tb/tb_decodificador_n_seq.sv
// Directed, table-driven bench for decodificador_n_seq (N=2/SCAN_DIV=4) plus an N=3/SCAN_DIV=1 scan run.
module tb_decodificador_n_seq;
    logic clk = 1'b0;
    logic rst;
    logic rst3;

    always #5 clk = ~clk;

    decodificador_n_seq_if #(.N(2)) bus2 ();
    decodificador_n_seq_if #(.N(3)) bus3 ();

    decodificador_n_seq #(.N(2), .SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    decodificador_n_seq #(.N(3), .SCAN_DIV(1)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3.slave)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       modo;
        logic       load;
        logic [1:0] sel;
        logic [3:0] y;
        logic [1:0] idx;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input int rep, input logic r, input logic e, input logic m,
                       input logic l, input logic [1:0] s,
                       input logic [3:0] y, input logic [1:0] i, input logic w);
        vec_t v;
        v.rst = r; v.en = e; v.modo = m; v.load = l; v.sel = s;
        v.y = y; v.idx = i; v.wrap = w;
        for (int k = 0; k < rep; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [2:0] exp_idx3;
        logic [7:0] one8;

        rst = 1'b1; rst3 = 1'b1;
        bus2.en = 1'b1; bus2.modo = 1'b1; bus2.load = 1'b0; bus2.sel = '0;
        bus3.en = 1'b1; bus3.modo = 1'b1; bus3.load = 1'b0; bus3.sel = '0;

        //   rep rst en modo load sel  Y        idx wrap
        add(2,  1, 1, 1, 0, 2'd0, 4'b0000, 2'd0, 0);   // reset held with scan selected
        add(3,  0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 0);   // release: Y shows idx 0
        add(1,  0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0);
        add(3,  0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0);
        add(1,  0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0);
        add(3,  0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0);
        add(1,  0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 0);
        add(3,  0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 0);
        add(1,  0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 1);   // wrap step
        add(3,  0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 0);   // wrap lasts one cycle only
        add(1,  0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0);
        add(2,  0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0);   // prescaler now 2
        add(6,  0, 0, 1, 1, 2'd3, 4'b0000, 2'd1, 0);   // blanked, frozen
        add(1,  0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0);   // resume, prescaler 3
        add(1,  0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0);
        add(5,  0, 1, 0, 0, 2'd3, 4'b0100, 2'd2, 0);   // scan->direct, hold without load
        add(1,  0, 1, 0, 1, 2'd3, 4'b1000, 2'd3, 0);
        add(1,  0, 1, 0, 1, 2'd2, 4'b0100, 2'd2, 0);
        add(1,  0, 1, 0, 0, 2'd0, 4'b0100, 2'd2, 0);
        add(1,  0, 1, 0, 1, 2'd0, 4'b0001, 2'd0, 0);
        add(1,  0, 1, 0, 1, 2'd1, 4'b0010, 2'd1, 0);
        add(3,  0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0);   // direct->scan: full period first
        add(1,  0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0);
        add(1,  0, 1, 1, 1, 2'd0, 4'b0100, 2'd2, 0);   // load ignored in scan
        add(1,  0, 1, 0, 1, 2'd3, 4'b1000, 2'd3, 0);   // modo 0 with load same edge
        add(1,  0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 0);
        add(1,  1, 1, 1, 0, 2'd0, 4'b0000, 2'd0, 0);   // reset mid-scan at idx 3
        add(1,  0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 0);
        add(1,  1, 0, 1, 0, 2'd0, 4'b0000, 2'd0, 0);
        add(1,  1, 1, 0, 1, 2'd3, 4'b0000, 2'd0, 0);   // reset beats load
        add(1,  0, 1, 0, 0, 2'd0, 4'b0001, 2'd0, 0);
        add(1,  0, 0, 0, 1, 2'd3, 4'b0000, 2'd0, 0);   // load ignored while blanked
        add(1,  0, 1, 0, 0, 2'd3, 4'b0001, 2'd0, 0);
        add(1,  0, 1, 0, 1, 2'd1, 4'b0010, 2'd1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            bus2.en   = vecs[i].en;
            bus2.modo = vecs[i].modo;
            bus2.load = vecs[i].load;
            bus2.sel  = vecs[i].sel;
            @(posedge clk);
            #1;
            $display("vec %0d: rst=%b en=%b modo=%b load=%b sel=%0d -> Y=%b idx=%0d wrap=%b",
                     i, vecs[i].rst, vecs[i].en, vecs[i].modo, vecs[i].load, vecs[i].sel,
                     bus2.Y, bus2.idx, bus2.wrap);
            check($sformatf("vec%0d Y", i), 32'(bus2.Y), 32'(vecs[i].y));
            check($sformatf("vec%0d idx", i), 32'(bus2.idx), 32'(vecs[i].idx));
            check($sformatf("vec%0d wrap", i), 32'(bus2.wrap), 32'(vecs[i].wrap));
`ifdef DECOD_PAR_EN
            check($sformatf("vec%0d f_par", i), 32'(bus2.f_par),
                  32'((vecs[i].y & 4'b0101) != 4'b0000));
`endif
        end

        // N=3, SCAN_DIV=1: one step per cycle, wrap every 8 cycles.
        @(negedge clk);
        rst3 = 1'b1;
        @(posedge clk);
        #1;
        check("n3 reset Y", 32'(bus3.Y), 32'd0);
        @(negedge clk);
        rst3 = 1'b0;
        exp_idx3 = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            exp_idx3 = exp_idx3 + 3'd1;
            one8 = 8'd1 << exp_idx3;
            $display("n3 cycle %0d: Y=%b idx=%0d wrap=%b", k, bus3.Y, bus3.idx, bus3.wrap);
            check($sformatf("n3 c%0d Y", k), 32'(bus3.Y), 32'(one8));
            check($sformatf("n3 c%0d idx", k), 32'(bus3.idx), 32'(exp_idx3));
            check($sformatf("n3 c%0d wrap", k), 32'(bus3.wrap), 32'(exp_idx3 == 3'd0));
        end
        @(negedge clk);
        bus3.en = 1'b0;
        @(posedge clk);
        #1;
        $display("n3 blank: Y=%b idx=%0d", bus3.Y, bus3.idx);
        check("n3 blank Y", 32'(bus3.Y), 32'd0);
        check("n3 blank idx", 32'(bus3.idx), 32'(exp_idx3));
        @(negedge clk);
        bus3.en = 1'b1;
        @(posedge clk);
        #1;
        exp_idx3 = exp_idx3 + 3'd1;
        one8 = 8'd1 << exp_idx3;
        $display("n3 resume: Y=%b idx=%0d", bus3.Y, bus3.idx);
        check("n3 resume Y", 32'(bus3.Y), 32'(one8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decodificador_n_seq.md
Name: decodificador_n_seq

Overview:
- Registered, parametrised N→2^N one-hot decoder.
- Generalises the combinational 2→4 decoder: arbitrary N, clocked outputs, an enable that blanks the outputs, and an auto-scan mode.
- In scan mode an internal prescaled counter walks the one-hot output across all 2^N lines, for display or row multiplexing.
- Sits between control logic and multiplexed loads (digit selects, row strobes).

Parameters:
- N, 2, select width; output width is 2^N.
- SCAN_DIV, 4, clock cycles per scan step; legal range ≥1; 1 means advance every cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  global enable; 0 blanks Y and freezes all state.
- modo  input  1  0 = direct (load sel), 1 = auto-scan.
- load  input  1  direct-mode strobe; sel sampled when load=1.
- sel  input  N  direct-mode index.
- Y  output  2^N  registered one-hot decode of idx; all zeros when blanked.
- idx  output  N  current index register.
- wrap  output  1  one-cycle pulse when scan wraps idx from 2^N-1 to 0.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - rst=1 at an edge: idx=0, prescaler=0, Y=0 (all lines off), wrap=0.
  - rst has priority over every other input, including mid-scan and mid-load.
- Output register:
  - Y is always registered. When en=1 and not in reset, Y[i]=1 iff i == next idx; all other bits 0.
  - Y is exactly one-hot or all-zero. No other pattern is legal.
- en=0:
  - Next edge: Y=0, wrap=0.
  - idx and prescaler are held; load is ignored.
  - On the edge after en returns to 1, Y resumes with the held idx. No step is skipped.
- Direct mode (modo=0):
  - load=1 and en=1 at edge k: idx←sel and Y←onehot(sel) at edge k. Visible one cycle after the strobe is presented (latency 1).
  - load=0: idx and Y hold.
  - Prescaler is held at 0; wrap=0.
- Scan mode (modo=1):
  - Prescaler counts 0..SCAN_DIV-1. When it equals SCAN_DIV-1 at an edge: prescaler←0 and idx←idx+1 modulo 2^N. Otherwise prescaler increments.
  - Y tracks the new idx in the same edge.
  - wrap=1 for exactly the one cycle following the step where idx went 2^N-1→0.
  - load and sel are ignored.
- Mode changes:
  - 0→1: scan starts from the current idx with prescaler=0. The first step occurs SCAN_DIV cycles later.
  - 1→0: idx holds its value until the next load. Prescaler is cleared.
  - When modo and load change in the same cycle, the modo value sampled at that edge decides.
- Width rules: idx wraps naturally at N bits. The prescaler is sized clog2(SCAN_DIV), minimum 1 bit.

Optional Feature:
- Macro: DECOD_PAR_EN.
- Defined:
  - Adds output port f_par (1 bit) = OR of all even-index bits of Y, i.e. ~idx[0] when enabled. This generalises f2 = Y0+Y2.
  - f_par is derived from the registered Y, so it has the same latency.
  - f_par=0 during reset and while blanked.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan (N=2, SCAN_DIV=4 unless noted):
- Reset: hold rst=1 for 2 cycles with en=1, modo=1 → Y=4'b0000, idx=0, wrap=0. Release → Y=4'b0001 on the first edge.
- Direct load: modo=0, en=1, pulse load with sel=2 → next cycle Y=4'b0100, idx=2. Then load=0 with sel=3 for 5 cycles → Y stays 4'b0100.
- Scan and wrap:
  - modo=1 from idx=0 → Y steps 0001→0010→0100→1000→0001, one step every 4 cycles.
  - wrap=1 only in the single cycle after the 1000→0001 step.
- Enable freeze: in scan at idx=1 with prescaler=2, drop en for 6 cycles → Y=0000 and idx=1 throughout. Raise en → Y=0010, then step to 0100 after 2 more cycles.
- Mid-operation reset and mode switch:
  - rst pulsed during scan at idx=3 → Y=0000, idx=0 next edge.
  - Switch modo 1→0 at idx=2 → Y stays 0100 until load.
  - With N=3, SCAN_DIV=1 → Y advances every cycle and wrap pulses every 8 cycles.
- With DECOD_PAR_EN: direct-load sel=0,1,2,3 → f_par=1,0,1,0 respectively. f_par=0 while en=0.
